gtfraw_vnc_rx_run_ctrl: RTL and testbench
=========================================

Name: gtfraw_vnc_rx_run_ctrl

Overview:
- Sequences measured runs of the GTF RAW RX latency monitor. Drives the monitor enable window (ctl_vnc_mon_en) and re-arms it for a configured number of SOF events.
- Measures arm-to-SOF delay per event, accumulates min/max/sum statistics, and terminates on completion, timeout or abort.
- Sits in the rx_clk domain between the control/status register block and the RX monitor.

Parameters:
- CNT_W, 16, width of event count and holdoff configuration
- DLY_W, 24, width of per-event delay counter and timeout
- SUM_W, 40, width of delay accumulator

Ports:
- rx_clk  in  1  RX user clock; the only clock
- rx_rst  in  1  synchronous, active-high reset
- start_run  in  1  pulse; starts a run when in IDLE, ignored otherwise
- abort_run  in  1  level/pulse; forces return to IDLE from any state
- cfg_num_events  in  CNT_W  events per run; 0 treated as 1
- cfg_holdoff  in  CNT_W  cycles with mon_en low between events; 0 treated as 1
- cfg_timeout  in  DLY_W  max ARM cycles per event; 0 disables timeout
- rx_sof  in  1  SOF marker from RX monitor (gtf_ch_rxrawdata_sof)
- ctl_vnc_mon_en  out  1  monitor enable window
- run_busy  out  1  high in any state other than IDLE
- run_done  out  1  one-cycle pulse at run end (normal, timeout or abort)
- run_timeout  out  1  sticky; set when the run ended by timeout, cleared on next accepted start
- run_aborted  out  1  sticky; set when the run ended by abort, cleared on next accepted start
- event_cnt  out  CNT_W  SOF events captured in current/last run
- last_delay  out  DLY_W  delay of most recent event
- delay_min  out  DLY_W  minimum event delay in run
- delay_max  out  DLY_W  maximum event delay in run
- delay_sum  out  SUM_W  sum of event delays in run

Behaviour:
- Reset values: all outputs 0; state IDLE. delay_min resets to all-ones.
- Config latch: cfg_* are latched on the cycle start_run is accepted and held constant for the whole run.
- States: IDLE, ARM, HOLDOFF, DONE.
- IDLE:
  - start_run=1 -> ARM next cycle.
  - Same cycle: clear event_cnt, last_delay, delay_max, delay_sum, run_timeout and run_aborted; set delay_min to all-ones; clear the delay counter.
- ARM:
  - ctl_vnc_mon_en=1 (registered, asserted the first cycle in ARM).
  - Delay counter starts at 0 on the first ARM cycle, +1 per cycle, saturates at all-ones.
  - rx_sof=1 while in ARM:
    - last_delay <= counter value.
    - event_cnt+1.
    - delay_sum += counter; delay_sum saturates at all-ones.
    - min/max updated with that value.
    - If event_cnt+1 equals the latched count -> DONE; else -> HOLDOFF.
  - Timeout: if the counter equals cfg_timeout-1 with no SOF and cfg_timeout≠0 -> DONE and set run_timeout.
  - SOF and timeout in the same cycle: SOF wins, no timeout.
- HOLDOFF:
  - ctl_vnc_mon_en=0.
  - Lasts exactly max(cfg_holdoff,1) cycles, then -> ARM with the delay counter cleared.
  - rx_sof is ignored here and in IDLE and DONE; no statistics change.
- DONE:
  - One cycle; run_done=1; -> IDLE.
  - Statistics hold until the next accepted start.
- abort_run:
  - Highest priority, from ARM or HOLDOFF -> DONE (run_done pulses, run_aborted set); statistics keep captured values.
  - abort_run in IDLE or DONE: no effect.
  - abort_run together with start_run in IDLE: start is ignored.
- rx_rst mid-run: immediate return to reset values; no run_done pulse.
- ctl_vnc_mon_en deasserts on the cycle after the SOF that is accepted, so a single window never yields two events.
- event_cnt saturates at all-ones (unreachable with a latched count ≤ all-ones).

Test Plan:
- Basic run: num_events=3, holdoff=4, timeout=0; SOF 10, 20, 5 cycles after each mon_en rise -> event_cnt=3, last_delay=5, min=5, max=20, sum=35; one run_done pulse; mon_en low exactly 4 cycles between windows.
- Timeout: num_events=2, timeout=100; SOF at delay 7, then no SOF -> DONE after 100 ARM cycles of the second window; run_timeout=1, event_cnt=1, sum=7.
- SOF on the timeout cycle: timeout=50, SOF at delay 49 -> event accepted, run_timeout=0, last_delay=49.
- Stray SOFs: pulse rx_sof in IDLE and HOLDOFF -> no statistics change; abort during HOLDOFF -> run_done pulse, run_aborted=1, run_busy=0 the next cycle.
- Degenerate config: num_events=0, holdoff=0 -> treated as 1 event; single SOF ends the run. start_run while busy is ignored; start_run+abort_run in IDLE stays IDLE.
- Reset mid-ARM: assert rx_rst -> all outputs 0, delay_min all-ones, no run_done; a subsequent start_run runs normally.

Source files
------------

// File: rtl/gtfraw_vnc_rx_run_ctrl.sv
// GTF RAW RX latency run controller: sequences monitor enable windows,
// measures arm-to-SOF delay per event and accumulates min/max/sum stats.
//
// Ports:
//   rx_clk, rx_rst        clock, synchronous active-high reset
//   start_run, abort_run  run control from the CSR block
//   cfg_num_events        events per run (0 means 1)
//   cfg_holdoff           mon_en low cycles between events (0 means 1)
//   cfg_timeout           max ARM cycles per event (0 disables)
//   rx_sof                SOF marker from the RX monitor
//   ctl_vnc_mon_en        monitor enable window
//   run_busy, run_done    run status / end-of-run pulse
//   run_timeout           sticky: the run ended by timeout
//   run_aborted           sticky: the run ended by abort
//   event_cnt             events captured in the run
//   last_delay            delay of the most recent event
//   delay_min, delay_max  delay extremes in the run
//   delay_sum             saturating delay sum in the run
module gtfraw_vnc_rx_run_ctrl #(
  parameter int CNT_W = 16,
  parameter int DLY_W = 24,
  parameter int SUM_W = 40
) (
  input  logic             rx_clk,
  input  logic             rx_rst,
  input  logic             start_run,
  input  logic             abort_run,
  input  logic [CNT_W-1:0] cfg_num_events,
  input  logic [CNT_W-1:0] cfg_holdoff,
  input  logic [DLY_W-1:0] cfg_timeout,
  input  logic             rx_sof,
  output logic             ctl_vnc_mon_en,
  output logic             run_busy,
  output logic             run_done,
  output logic             run_timeout,
  output logic             run_aborted,
  output logic [CNT_W-1:0] event_cnt,
  output logic [DLY_W-1:0] last_delay,
  output logic [DLY_W-1:0] delay_min,
  output logic [DLY_W-1:0] delay_max,
  output logic [SUM_W-1:0] delay_sum
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [DLY_W-1:0] tmo_q;
  logic [DLY_W-1:0] dly_q;
  logic             go;
  logic             in_arm;
  logic             in_hold;
  logic             abort_acc;
  logic             sof_acc;
  logic             tmo_hit;
  logic             last_evt;
  logic [CNT_W-1:0] evt_inc;
  logic [SUM_W:0]   sum_ext;

  assign in_arm    = (state_q == S_ARM);
  assign in_hold   = (state_q == S_HOLD);
  // abort beats start in IDLE, and beats SOF/timeout in ARM
  assign go        = (state_q == S_IDLE) && start_run && !abort_run;
  assign abort_acc = abort_run && (in_arm || in_hold);
  assign sof_acc   = in_arm && rx_sof && !abort_run;
  assign tmo_hit   = in_arm && !rx_sof && !abort_run &&
                     (tmo_q != '0) &&
                     (dly_q == tmo_q - DLY_W'(1));

  assign evt_inc  = (event_cnt == '1) ? event_cnt
                                      : event_cnt + CNT_W'(1);
  assign last_evt = (evt_inc == num_q);
  assign sum_ext  = {1'b0, delay_sum} + (SUM_W+1)'(dly_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (go) state_d = S_ARM;
      S_ARM: begin
        if (abort_acc)    state_d = S_DONE;
        else if (sof_acc) state_d = last_evt ? S_DONE : S_HOLD;
        else if (tmo_hit) state_d = S_DONE;
      end
      S_HOLD: begin
        if (abort_acc)              state_d = S_DONE;
        else if (hold_cnt_q == '0)  state_d = S_ARM;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q        <= S_IDLE;
      num_q          <= '0;
      hold_q         <= '0;
      hold_cnt_q     <= '0;
      tmo_q          <= '0;
      dly_q          <= '0;
      ctl_vnc_mon_en <= 1'b0;
      run_busy       <= 1'b0;
      run_done       <= 1'b0;
      run_timeout    <= 1'b0;
      run_aborted    <= 1'b0;
      event_cnt      <= '0;
      last_delay     <= '0;
      delay_min      <= '1;
      delay_max      <= '0;
      delay_sum      <= '0;
    end else begin
      state_q        <= state_d;
      ctl_vnc_mon_en <= (state_d == S_ARM);
      run_busy       <= (state_d != S_IDLE);
      run_done       <= (state_d == S_DONE);

      // counter is zero everywhere but ARM, so each window starts at 0
      if (in_arm) begin
        if (dly_q != '1) dly_q <= dly_q + DLY_W'(1);
      end else begin
        dly_q <= '0;
      end

      if (go) begin
        num_q <= (cfg_num_events == '0) ? CNT_W'(1)
                                        : cfg_num_events;
        hold_q <= (cfg_holdoff == '0) ? CNT_W'(1)
                                      : cfg_holdoff;
        tmo_q       <= cfg_timeout;
        event_cnt   <= '0;
        last_delay  <= '0;
        delay_min   <= '1;
        delay_max   <= '0;
        delay_sum   <= '0;
        run_timeout <= 1'b0;
        run_aborted <= 1'b0;
      end

      if (sof_acc) begin
        hold_cnt_q <= hold_q - CNT_W'(1);
        last_delay <= dly_q;
        event_cnt  <= evt_inc;
        delay_sum  <= sum_ext[SUM_W] ? '1
                                     : sum_ext[SUM_W-1:0];
        if (dly_q < delay_min) delay_min <= dly_q;
        if (dly_q > delay_max) delay_max <= dly_q;
      end else if (in_hold && hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - CNT_W'(1);
      end

      if (tmo_hit)   run_timeout <= 1'b1;
      if (abort_acc) run_aborted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gtfraw_vnc_rx_run_ctrl.sv
// Testbench for gtfraw_vnc_rx_run_ctrl: table-driven runs,
// hand-written corner sequences and randomized runs vs a run model.
module tb_gtfraw_vnc_rx_run_ctrl;

  localparam int CNT_W = 16;
  localparam int DLY_W = 24;
  localparam int SUM_W = 40;
  localparam int MINR  = 24'hFFFFFF;

  logic             rx_clk = 1'b0;
  logic             rx_rst;
  logic             start_run;
  logic             abort_run;
  logic [CNT_W-1:0] cfg_num_events;
  logic [CNT_W-1:0] cfg_holdoff;
  logic [DLY_W-1:0] cfg_timeout;
  logic             rx_sof;
  logic             ctl_vnc_mon_en;
  logic             run_busy;
  logic             run_done;
  logic             run_timeout;
  logic             run_aborted;
  logic [CNT_W-1:0] event_cnt;
  logic [DLY_W-1:0] last_delay;
  logic [DLY_W-1:0] delay_min;
  logic [DLY_W-1:0] delay_max;
  logic [SUM_W-1:0] delay_sum;

  gtfraw_vnc_rx_run_ctrl #(
    .CNT_W(CNT_W), .DLY_W(DLY_W), .SUM_W(SUM_W)
  ) dut (
    .rx_clk(rx_clk),
    .rx_rst(rx_rst),
    .start_run(start_run),
    .abort_run(abort_run),
    .cfg_num_events(cfg_num_events),
    .cfg_holdoff(cfg_holdoff),
    .cfg_timeout(cfg_timeout),
    .rx_sof(rx_sof),
    .ctl_vnc_mon_en(ctl_vnc_mon_en),
    .run_busy(run_busy),
    .run_done(run_done),
    .run_timeout(run_timeout),
    .run_aborted(run_aborted),
    .event_cnt(event_cnt),
    .last_delay(last_delay),
    .delay_min(delay_min),
    .delay_max(delay_max),
    .delay_sum(delay_sum)
  );

  always #5 rx_clk = ~rx_clk;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    int num, hold, tmo;
    int d0, d1, d2, d3;
    int stray;
    int e_cnt, e_last, e_min, e_max, e_sum, e_tmo;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  nm, act, exp);
  endtask

  task automatic step();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/mon_en"}, 64'(ctl_vnc_mon_en), 0);
    chk({tag, "/busy"}, 64'(run_busy), 0);
    chk({tag, "/done"}, 64'(run_done), 0);
    chk({tag, "/tmo"}, 64'(run_timeout), 0);
    chk({tag, "/abt"}, 64'(run_aborted), 0);
    chk({tag, "/cnt"}, 64'(event_cnt), 0);
    chk({tag, "/last"}, 64'(last_delay), 0);
    chk({tag, "/min"}, 64'(delay_min), 64'(MINR));
    chk({tag, "/max"}, 64'(delay_max), 0);
    chk({tag, "/sum"}, 64'(delay_sum), 0);
  endtask

  // Run-level model: each window either catches its SOF at
  // delay d or times out after tmo cycles if d >= tmo.
  task automatic model(input int num, input int tmo,
                       input int d[8],
                       output int cnt, output int last,
                       output int mn, output int mx,
                       output int sum, output int to);
    int n;
    n = (num == 0) ? 1 : num;
    cnt = 0; last = 0; mn = MINR;
    mx = 0; sum = 0; to = 0;
    for (int i = 0; i < n; i++) begin
      if (tmo != 0 && d[i] >= tmo) begin
        to = 1;
        break;
      end
      cnt++;
      last = d[i];
      sum += d[i];
      if (d[i] < mn) mn = d[i];
      if (d[i] > mx) mx = d[i];
    end
  endtask

  task automatic do_run(input int num, input int hold,
                        input int tmo, input int d[8],
                        input int stray,
                        input int e_cnt, input int e_last,
                        input int e_min, input int e_max,
                        input int e_sum, input int e_tmo,
                        input string tag);
    int len, win, gap, egap, elen, dw;
    bit prev, en, fin;
    len = 0; win = 0; gap = 0;
    prev = 0; fin = 0;
    egap = (hold == 0) ? 1 : hold;
    cfg_num_events = CNT_W'(num);
    cfg_holdoff    = CNT_W'(hold);
    cfg_timeout    = DLY_W'(tmo);
    start_run = 1'b1;
    step();
    start_run = 1'b0;
    chk({tag, "/busy"}, 64'(run_busy), 1);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      en = ctl_vnc_mon_en;
      dw = d[win & 7];
      if (prev && !en) begin
        elen = (tmo != 0 && dw >= tmo) ? tmo : dw + 1;
        chk({tag, "/winlen"}, 64'(len), 64'(elen));
        win++;
        gap = 0;
      end
      if (run_done) begin
        fin = 1;
      end else begin
        if (en) begin
          if (!prev) begin
            if (win > 0)
              chk({tag, "/gap"}, 64'(gap), 64'(egap));
            len = 0;
          end
          rx_sof = (len == d[win & 7]);
          len++;
        end else begin
          gap++;
          rx_sof = (stray != 0) ?
                   1'($urandom_range(0, 1)) : 1'b0;
        end
        prev = en;
        step();
        rx_sof = 1'b0;
      end
    end
    if (!fin) chk({tag, "/done_seen"}, 0, 1);
    chk({tag, "/cnt"}, 64'(event_cnt), 64'(e_cnt));
    chk({tag, "/last"}, 64'(last_delay), 64'(e_last));
    chk({tag, "/min"}, 64'(delay_min), 64'(e_min));
    chk({tag, "/max"}, 64'(delay_max), 64'(e_max));
    chk({tag, "/sum"}, 64'(delay_sum), 64'(e_sum));
    chk({tag, "/tmo"}, 64'(run_timeout), 64'(e_tmo));
    chk({tag, "/abt"}, 64'(run_aborted), 0);
    step();
    chk({tag, "/done_1cyc"}, 64'(run_done), 0);
    chk({tag, "/idle"}, 64'(run_busy), 0);
  endtask

  initial begin
    int d[8];
    int c, l, mn, mx, s, to, num, hold, tmo, st;

    rx_rst = 1'b1;
    start_run = 1'b0;
    abort_run = 1'b0;
    rx_sof = 1'b0;
    cfg_num_events = '0;
    cfg_holdoff = '0;
    cfg_timeout = '0;
    repeat (3) step();
    rx_rst = 1'b0;
    step();
    chk_reset("reset");

    tbl[0] = '{3, 4, 0, 10, 20, 5, 0, 0, 3, 5, 5, 20, 35, 0};
    tbl[1] = '{2, 3, 100, 7, 200, 0, 0, 0, 1, 7, 7, 7, 7, 1};
    tbl[2] = '{1, 1, 50, 49, 0, 0, 0, 0, 1, 49, 49, 49, 49, 0};
    tbl[3] = '{0, 0, 0, 3, 0, 0, 0, 0, 1, 3, 3, 3, 3, 0};
    tbl[4] = '{2, 0, 10, 0, 9, 0, 0, 0, 2, 9, 0, 9, 9, 0};
    tbl[5] = '{1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 2, 1, 5, 0, 0, 0, 0, 0, 0, MINR, 0, 0, 1};
    tbl[7] = '{4, 1, 0, 1, 1, 1, 1, 1, 4, 1, 1, 1, 4, 0};

    for (int i = 0; i < 8; i++) begin
      d = '{default: 0};
      d[0] = tbl[i].d0; d[1] = tbl[i].d1;
      d[2] = tbl[i].d2; d[3] = tbl[i].d3;
      do_run(tbl[i].num, tbl[i].hold, tbl[i].tmo, d,
             tbl[i].stray, tbl[i].e_cnt, tbl[i].e_last,
             tbl[i].e_min, tbl[i].e_max, tbl[i].e_sum,
             tbl[i].e_tmo, $sformatf("t%0d", i));
    end

    // stray SOFs in IDLE leave the last run's stats alone
    rx_sof = 1'b1;
    repeat (3) step();
    rx_sof = 1'b0;
    step();
    chk("idle_sof/cnt", 64'(event_cnt), 64'(tbl[7].e_cnt));
    chk("idle_sof/sum", 64'(delay_sum), 64'(tbl[7].e_sum));
    chk("idle_sof/busy", 64'(run_busy), 0);

    // abort during HOLDOFF
    cfg_num_events = 3; cfg_holdoff = 10; cfg_timeout = 0;
    start_run = 1'b1; step(); start_run = 1'b0;
    step(); step();
    rx_sof = 1'b1; step(); rx_sof = 1'b0;
    chk("abt/hold_mon", 64'(ctl_vnc_mon_en), 0);
    chk("abt/cnt1", 64'(event_cnt), 1);
    rx_sof = 1'b1; step(); rx_sof = 1'b0;
    abort_run = 1'b1; step(); abort_run = 1'b0;
    chk("abt/done", 64'(run_done), 1);
    chk("abt/flag", 64'(run_aborted), 1);
    step();
    chk("abt/busy", 64'(run_busy), 0);
    chk("abt/done_1cyc", 64'(run_done), 0);
    chk("abt/cnt", 64'(event_cnt), 1);
    chk("abt/last", 64'(last_delay), 2);
    chk("abt/sum", 64'(delay_sum), 2);

    // start while busy is ignored; config stays latched
    cfg_num_events = 2; cfg_holdoff = 2;
    start_run = 1'b1; step();
    cfg_num_events = 1;
    step(); start_run = 1'b0;
    rx_sof = 1'b1; step(); rx_sof = 1'b0;
    chk("busy_start/done", 64'(run_done), 0);
    chk("busy_start/busy", 64'(run_busy), 1);
    chk("busy_start/cnt", 64'(event_cnt), 1);
    chk("busy_start/abt_clr", 64'(run_aborted), 0);
    abort_run = 1'b1; step(); abort_run = 1'b0;
    step();

    // start together with abort in IDLE stays IDLE
    start_run = 1'b1; abort_run = 1'b1; step();
    start_run = 1'b0; abort_run = 1'b0;
    chk("st_abt/busy", 64'(run_busy), 0);
    chk("st_abt/mon", 64'(ctl_vnc_mon_en), 0);
    step();
    chk("st_abt/busy2", 64'(run_busy), 0);
    chk("st_abt/abt", 64'(run_aborted), 1);

    // reset while armed
    cfg_num_events = 2; cfg_holdoff = 1; cfg_timeout = 0;
    start_run = 1'b1; step(); start_run = 1'b0;
    step(); step();
    rx_sof = 1'b1; step(); rx_sof = 1'b0;
    step(); step();
    chk("rst_arm/mon", 64'(ctl_vnc_mon_en), 1);
    rx_rst = 1'b1; step();
    chk_reset("rst_arm");
    rx_rst = 1'b0; step();
    chk("rst_arm/idle", 64'(run_busy), 0);
    chk("rst_arm/no_done", 64'(run_done), 0);
    d = '{default: 0};
    d[0] = 10; d[1] = 20; d[2] = 5;
    do_run(3, 4, 0, d, 0, 3, 5, 5, 20, 35, 0, "post_rst");

    // randomized runs against the run model
    for (int r = 0; r < 25; r++) begin
      num  = int'($urandom_range(0, 5));
      hold = int'($urandom_range(0, 5));
      tmo  = ($urandom_range(0, 2) == 0) ?
             0 : int'($urandom_range(1, 30));
      st   = int'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++)
        d[k] = int'($urandom_range(0,
                    (tmo != 0) ? tmo + 2 : 30));
      model(num, tmo, d, c, l, mn, mx, s, to);
      do_run(num, hold, tmo, d, st, c, l, mn, mx, s, to,
             $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
